// File: rtl/cpu_pkg.sv
// cpu_pkg: constants shared across the 16-bit CPU datapath.
//   WORD_W      - machine word width in bits
//   STACK_DEPTH - default number of entries in the hardware return/operand stack
package cpu_pkg;

   localparam int WORD_W      = 16;
   localparam int STACK_DEPTH = 16;

endpackage : cpu_pkg

// File: rtl/hw_stack_if.sv
// hw_stack_if: request/status bundle between the control unit and hw_stack.
//   master modport (control unit): drives i_push, i_pop, i_data, i_clr_err;
//                                  observes o_top, o_count, o_empty, o_full, o_ovf, o_unf
//   slave modport  (hw_stack):     the reverse
// DEPTH and WIDTH must match the parameters of the hw_stack instance on the slave side.
interface hw_stack_if
   import cpu_pkg::*;
#(
   parameter int DEPTH = STACK_DEPTH,
   parameter int WIDTH = WORD_W
);

   localparam int CW = $clog2(DEPTH + 1);

   logic             i_push;
   logic             i_pop;
   logic [WIDTH-1:0] i_data;
   logic             i_clr_err;
   logic [WIDTH-1:0] o_top;
   logic [CW-1:0]    o_count;
   logic             o_empty;
   logic             o_full;
   logic             o_ovf;
   logic             o_unf;

   modport master (
      output i_push, i_pop, i_data, i_clr_err,
      input  o_top, o_count, o_empty, o_full, o_ovf, o_unf
   );

   modport slave (
      input  i_push, i_pop, i_data, i_clr_err,
      output o_top, o_count, o_empty, o_full, o_ovf, o_unf
   );

endinterface : hw_stack_if

// File: rtl/hwstack_mem.sv
// hwstack_mem: stack storage array. Not reset; contents are only meaningful
// below the owner's pointer.
//   i_clk   - clock, rising edge
//   i_we    - write enable, sampled at rising edge
//   i_waddr - write address
//   i_wdata - write data
//   i_raddr - asynchronous read address
//   o_rdata - asynchronous read data
module hwstack_mem #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 16,
   localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             i_clk,
   input  logic             i_we,
   input  logic [AW-1:0]    i_waddr,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic [AW-1:0]    i_raddr,
   output logic [WIDTH-1:0] o_rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = mem[i_raddr];

endmodule : hwstack_mem

// File: rtl/hw_stack.sv
// hw_stack: hardware LIFO for return addresses and pushed operands.
//   i_clk   - clock, rising edge
//   i_rst_n - asynchronous active-low reset
//   bus     - hw_stack_if.slave: push/pop/data/clr_err requests in,
//             top/count/empty/full/ovf/unf status out
// Build option: define HWSTACK_ERR_EN to get sticky overflow/underflow flags
// cleared by i_clr_err; otherwise o_ovf/o_unf are tied low and i_clr_err is ignored.
// Illegal operations are dropped in both builds.
module hw_stack
   import cpu_pkg::*;
#(
   parameter int DEPTH = STACK_DEPTH,
   parameter int WIDTH = WORD_W
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   hw_stack_if.slave  bus
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [CW-1:0]    cnt;
   logic [CW-1:0]    cnt_nxt;
   logic             empty;
   logic             full;
   logic             push_only;
   logic             pop_only;
   logic             replace;
   logic             wr_en;
   logic [AW-1:0]    wr_addr;
   logic [AW-1:0]    top_addr;
   logic [WIDTH-1:0] rd_data;

   assign empty     = (cnt == '0);
   assign full      = (cnt == CW'(DEPTH));
   assign push_only = bus.i_push & ~bus.i_pop;
   assign pop_only  = bus.i_pop & ~bus.i_push;
   // push+pop on a non-empty stack overwrites the top in place, even when full
   assign replace   = bus.i_push & bus.i_pop & ~empty;

   // cnt-1 wraps when empty; the read result is masked to 0 in that case
   assign top_addr  = AW'(cnt - CW'(1));

   // push+pop on an empty stack degenerates to a plain push at slot 0
   assign wr_en     = bus.i_push & (bus.i_pop | ~full);
   assign wr_addr   = replace ? top_addr : AW'(cnt);

   always_comb begin
      cnt_nxt = cnt;
      if (bus.i_push && !bus.i_pop && !full) begin
         cnt_nxt = cnt + CW'(1);
      end else if (pop_only && !empty) begin
         cnt_nxt = cnt - CW'(1);
      end else if (bus.i_push && bus.i_pop && empty) begin
         cnt_nxt = CW'(1);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt <= '0;
      end else begin
         cnt <= cnt_nxt;
      end
   end

   hwstack_mem #(
      .DEPTH (DEPTH),
      .WIDTH (WIDTH)
   ) u_mem (
      .i_clk   (i_clk),
      .i_we    (wr_en),
      .i_waddr (wr_addr),
      .i_wdata (bus.i_data),
      .i_raddr (top_addr),
      .o_rdata (rd_data)
   );

   assign bus.o_top   = empty ? '0 : rd_data;
   assign bus.o_count = cnt;
   assign bus.o_empty = empty;
   assign bus.o_full  = full;

`ifdef HWSTACK_ERR_EN
   logic ovf_ev;
   logic unf_ev;
   logic ovf_q;
   logic unf_q;

   assign ovf_ev = push_only & full;
   // covers both a bare pop and the pop half of push+pop on an empty stack
   assign unf_ev = bus.i_pop & empty;

   // a new event wins over a simultaneous clear
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         if (ovf_ev) begin
            ovf_q <= 1'b1;
         end else if (bus.i_clr_err) begin
            ovf_q <= 1'b0;
         end
         if (unf_ev) begin
            unf_q <= 1'b1;
         end else if (bus.i_clr_err) begin
            unf_q <= 1'b0;
         end
      end
   end

   assign bus.o_ovf = ovf_q;
   assign bus.o_unf = unf_q;
`else
   assign bus.o_ovf = 1'b0;
   assign bus.o_unf = 1'b0;
`endif

endmodule : hw_stack

// File: tb/tb_hw_stack.sv
// tb_hw_stack: directed and random checks of hw_stack (DEPTH=4) against a
// queue-based LIFO model; expectations are queued at drive time and popped
// after the sampling edge.
module tb_hw_stack;
   import cpu_pkg::*;

   localparam int DEPTH = 4;
   localparam int WIDTH = WORD_W;

`ifdef HWSTACK_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   typedef struct {
      logic [WIDTH-1:0] top;
      int               count;
      logic             ovf;
      logic             unf;
   } exp_t;

   logic i_clk   = 1'b0;
   logic i_rst_n = 1'b0;

   always #5 i_clk = ~i_clk;

   hw_stack_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

   hw_stack #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .bus     (bus.slave)
   );

   exp_t             sb[$];
   logic [WIDTH-1:0] mdl[$];
   logic             m_ovf = 1'b0;
   logic             m_unf = 1'b0;
   int               checks = 0;
   int               errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [WIDTH-1:0] m_top();
      return (mdl.size() == 0) ? '0 : mdl[mdl.size()-1];
   endfunction

   task automatic op(input logic p, input logic q, input logic [WIDTH-1:0] d, input logic clr);
      exp_t e;
      logic ov, un;
      @(negedge i_clk);
      bus.i_push    = p;
      bus.i_pop     = q;
      bus.i_data    = d;
      bus.i_clr_err = clr;
      #1;
      // top is visible before the edge, including the value about to be popped
      chk("top_pre", 32'(bus.o_top), 32'(m_top()));
      ov = 1'b0;
      un = 1'b0;
      if (p && q) begin
         if (mdl.size() == 0) begin
            mdl.push_back(d);
            un = 1'b1;
         end else begin
            mdl[mdl.size()-1] = d;
         end
      end else if (p) begin
         if (mdl.size() == DEPTH) ov = 1'b1;
         else mdl.push_back(d);
      end else if (q) begin
         if (mdl.size() == 0) un = 1'b1;
         else void'(mdl.pop_back());
      end
      if (ERR_EN) begin
         m_ovf = ov ? 1'b1 : (clr ? 1'b0 : m_ovf);
         m_unf = un ? 1'b1 : (clr ? 1'b0 : m_unf);
      end
      e.top   = m_top();
      e.count = mdl.size();
      e.ovf   = m_ovf;
      e.unf   = m_unf;
      sb.push_back(e);
      @(posedge i_clk);
      #1;
      if (sb.size() == 0) begin
         chk("scoreboard_empty", 32'd1, 32'd0);
      end else begin
         e = sb.pop_front();
         chk("top",   32'(bus.o_top),   32'(e.top));
         chk("count", 32'(bus.o_count), 32'(e.count));
         chk("empty", 32'(bus.o_empty), 32'(e.count == 0));
         chk("full",  32'(bus.o_full),  32'(e.count == DEPTH));
         chk("ovf",   32'(bus.o_ovf),   32'(e.ovf));
         chk("unf",   32'(bus.o_unf),   32'(e.unf));
      end
   endtask

   task automatic idle_inputs();
      bus.i_push    = 1'b0;
      bus.i_pop     = 1'b0;
      bus.i_data    = '0;
      bus.i_clr_err = 1'b0;
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_count"}, 32'(bus.o_count), 32'd0);
      chk({tag, "_empty"}, 32'(bus.o_empty), 32'd1);
      chk({tag, "_full"},  32'(bus.o_full),  32'd0);
      chk({tag, "_top"},   32'(bus.o_top),   32'd0);
      chk({tag, "_ovf"},   32'(bus.o_ovf),   32'd0);
      chk({tag, "_unf"},   32'(bus.o_unf),   32'd0);
   endtask

   initial begin
      logic p, q, c;
      idle_inputs();
      #3;
      chk_reset_state("por");
      @(negedge i_clk);
      i_rst_n = 1'b1;

      // reset asserted mid-cycle while a push is in flight
      op(1'b1, 1'b0, 16'hAAAA, 1'b0);
      op(1'b1, 1'b0, 16'h5555, 1'b0);
      op(1'b1, 1'b0, 16'h7777, 1'b0);
      #2;
      i_rst_n = 1'b0;
      #1;
      chk_reset_state("async_rst");
      mdl.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      @(negedge i_clk);
      idle_inputs();
      @(negedge i_clk);
      i_rst_n = 1'b1;

      // fill, overflow, clear, drain
      op(1'b1, 1'b0, 16'h0115, 1'b0);
      op(1'b1, 1'b0, 16'h0114, 1'b0);
      op(1'b1, 1'b0, 16'h01FF, 1'b0);
      op(1'b1, 1'b0, 16'h0041, 1'b0);
      op(1'b1, 1'b0, 16'hBEEF, 1'b0);
      op(1'b0, 1'b0, 16'h0000, 1'b1);
      op(1'b1, 1'b1, 16'h0042, 1'b0);
      op(1'b1, 1'b1, 16'h0041, 1'b0);
      for (int i = 0; i < 4; i++) op(1'b0, 1'b1, 16'h0000, 1'b0);

      // underflow, then clear
      op(1'b0, 1'b1, 16'h0000, 1'b0);
      op(1'b0, 1'b0, 16'h0000, 1'b0);
      op(1'b0, 1'b0, 16'h0000, 1'b1);

      // replace with count 2, then push+pop on empty
      op(1'b1, 1'b0, 16'h0115, 1'b0);
      op(1'b1, 1'b0, 16'h0114, 1'b0);
      op(1'b1, 1'b1, 16'h1234, 1'b0);
      op(1'b0, 1'b1, 16'h0000, 1'b0);
      op(1'b0, 1'b1, 16'h0000, 1'b0);
      op(1'b1, 1'b1, 16'h0007, 1'b0);
      // event and clear together: event wins
      op(1'b0, 1'b1, 16'h0000, 1'b0);
      op(1'b0, 1'b1, 16'h0000, 1'b1);
      op(1'b0, 1'b0, 16'h0000, 1'b1);

      for (int i = 0; i < 1000; i++) begin
         p = 1'($urandom_range(0, 1));
         q = 1'($urandom_range(0, 1));
         c = ($urandom_range(0, 15) == 0);
         op(p, q, 16'($urandom), c);
      end

      @(negedge i_clk);
      idle_inputs();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_hw_stack
